// File: rtl/boid_frame_writer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : boid_frame_writer                                          |
// | Description : Double-buffered 1-bit boid frame memory for the VGA path.  |
// |               The display bank serves registered pixel reads while the   |
// |               back bank is cleared and redrawn from the boid engine.     |
// |               Banks swap on a screen_end rising edge once drawing ends.  |
// | Options     : BOID_FRAME_WIDE_EN - plot a 2x2 memory-pixel block per     |
// |               boid (4-cycle PLOT) instead of a single pixel.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module boid_frame_writer #(
  parameter int NUM_BOIDS = 32,
  parameter int IDX_W     = $clog2(NUM_BOIDS),
  parameter int MEM_W     = 320,
  parameter int MEM_H     = 480,
  parameter int ADDR_W    = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              screen_end,
  input  logic [ADDR_W-1:0] read_address,
  output logic              read_data,
  output logic              boid_req,
  output logic [IDX_W-1:0]  boid_index,
  input  logic              boid_valid,
  input  logic [9:0]        boid_x,
  input  logic [8:0]        boid_y,
  output logic              busy,
  output logic [15:0]       frame_count,
  output logic [7:0]        overrun_count
);

  localparam int c_MEM_SIZE = MEM_W * MEM_H;
  localparam int c_MEM_AW   = $clog2(c_MEM_SIZE);
  localparam logic [c_MEM_AW-1:0] c_LAST_ADDR = c_MEM_AW'(c_MEM_SIZE - 1);
  localparam logic [IDX_W-1:0]    c_LAST_BOID = IDX_W'(NUM_BOIDS - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_CLEAR = 3'd1;
  localparam logic [2:0] c_FETCH = 3'd2;
  localparam logic [2:0] c_PLOT  = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  logic [2:0]          r_state;
  logic                r_display_bank;
  logic                r_display_valid;
  logic                r_se_prev;
  logic [c_MEM_AW-1:0] r_clr_addr;
  logic [IDX_W-1:0]    r_boid_index;
  logic [9:0]          r_x;
  logic [8:0]          r_y;
  logic [15:0]         r_frame_count;
  logic [7:0]          r_overrun_count;
  logic                r_read_data;
`ifdef BOID_FRAME_WIDE_EN
  logic [1:0]          r_sub;
`endif

  logic r_mem0 [0:c_MEM_SIZE-1];
  logic r_mem1 [0:c_MEM_SIZE-1];

  logic                w_se_rise;
  logic                w_busy;
  logic                w_dx;
  logic                w_dy;
  logic                w_plot_last;
  logic [9:0]          w_col;
  logic [9:0]          w_row;
  logic                w_plot_ok;
  logic [c_MEM_AW-1:0] w_plot_addr;
  logic                w_we;
  logic [c_MEM_AW-1:0] w_waddr;
  logic                w_wdata;

  assign w_se_rise = screen_end & ~r_se_prev;
  assign w_busy    = (r_state == c_CLEAR) || (r_state == c_FETCH) || (r_state == c_PLOT);

`ifdef BOID_FRAME_WIDE_EN
  // Sub-step walks the 2x2 block: bit 0 selects column offset, bit 1 row offset.
  assign w_dx        = r_sub[0];
  assign w_dy        = r_sub[1];
  assign w_plot_last = (r_sub == 2'd3);
`else
  assign w_dx        = 1'b0;
  assign w_dy        = 1'b0;
  assign w_plot_last = 1'b1;
`endif

  // Two screen columns share one memory pixel, hence x/2.
  assign w_col       = {1'b0, r_x[9:1]} + {9'd0, w_dx};
  assign w_row       = {1'b0, r_y} + {9'd0, w_dy};
  // Off-screen boids are dropped; block pixels past an edge are skipped, never wrapped.
  assign w_plot_ok   = (int'(r_x) < 2 * MEM_W) && (int'(r_y) < MEM_H) &&
                       (int'(w_col) < MEM_W) && (int'(w_row) < MEM_H);
  assign w_plot_addr = c_MEM_AW'(w_col) + c_MEM_AW'(w_row) * c_MEM_AW'(MEM_W);

  // Single write port: clearing in CLEAR, setting plotted pixels in PLOT.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = 1'b0;
    if (r_state == c_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_addr;
      w_wdata = 1'b0;
    end else if ((r_state == c_PLOT) && w_plot_ok) begin
      w_we    = 1'b1;
      w_waddr = w_plot_addr;
      w_wdata = 1'b1;
    end
  end

  // Writes always land in the back bank (the one not being displayed).
  always_ff @(posedge clk) begin
    if (w_we) begin
      if (r_display_bank) r_mem0[w_waddr] <= w_wdata;
      else                r_mem1[w_waddr] <= w_wdata;
    end
  end

  // Registered display read, masked until the first completed frame is shown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_data <= 1'b0;
    end else if (r_display_valid && (int'(read_address) < c_MEM_SIZE)) begin
      r_read_data <= r_display_bank ? r_mem1[read_address[c_MEM_AW-1:0]]
                                    : r_mem0[read_address[c_MEM_AW-1:0]];
    end else begin
      r_read_data <= 1'b0;
    end
  end

  // Frame sequencer: clear back bank, fetch and plot every boid, wait for swap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= c_CLEAR;
      r_display_bank  <= 1'b0;
      r_display_valid <= 1'b0;
      r_se_prev       <= 1'b0;
      r_clr_addr      <= '0;
      r_boid_index    <= '0;
      r_x             <= '0;
      r_y             <= '0;
      r_frame_count   <= '0;
      r_overrun_count <= '0;
`ifdef BOID_FRAME_WIDE_EN
      r_sub           <= '0;
`endif
    end else begin
      r_se_prev <= screen_end;
      case (r_state)
        c_CLEAR: begin
          if (r_clr_addr == c_LAST_ADDR) begin
            r_clr_addr   <= '0;
            r_boid_index <= '0;
            r_state      <= c_FETCH;
          end else begin
            r_clr_addr <= r_clr_addr + c_MEM_AW'(1);
          end
        end
        c_FETCH: begin
          if (boid_valid) begin
            r_x     <= boid_x;
            r_y     <= boid_y;
            r_state <= c_PLOT;
`ifdef BOID_FRAME_WIDE_EN
            r_sub   <= '0;
`endif
          end
        end
        c_PLOT: begin
`ifdef BOID_FRAME_WIDE_EN
          r_sub <= r_sub + 2'd1;
`endif
          if (w_plot_last) begin
            if (r_boid_index == c_LAST_BOID) begin
              r_state <= c_DONE;
            end else begin
              r_boid_index <= r_boid_index + IDX_W'(1);
              r_state      <= c_FETCH;
            end
          end
        end
        c_DONE, c_IDLE: begin
          if (w_se_rise) begin
            r_display_bank  <= ~r_display_bank;
            r_display_valid <= 1'b1;
            r_frame_count   <= r_frame_count + 16'd1;
            r_clr_addr      <= '0;
            r_state         <= c_CLEAR;
          end else begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_CLEAR;
      endcase
      // A boundary arriving while still drawing is counted, not acted on.
      if (w_se_rise && w_busy && (r_overrun_count != 8'hFF)) begin
        r_overrun_count <= r_overrun_count + 8'd1;
      end
    end
  end

  assign read_data     = r_read_data;
  assign boid_req      = (r_state == c_FETCH);
  assign boid_index    = r_boid_index;
  assign busy          = w_busy;
  assign frame_count   = r_frame_count;
  assign overrun_count = r_overrun_count;

endmodule
`default_nettype wire

// File: tb/tb_boid_frame_writer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_boid_frame_writer                                       |
// | Description : Self-checking bench for boid_frame_writer on a reduced     |
// |               frame size, with a per-frame expected image model.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_boid_frame_writer;

  localparam int NB   = 8;
  localparam int MW   = 32;
  localparam int MH   = 24;
  localparam int AW   = 20;
  localparam int SIZE = MW * MH;

  logic          clk = 1'b0;
  logic          reset;
  logic          screen_end;
  logic [AW-1:0] read_address;
  logic          read_data;
  logic          boid_req;
  logic [2:0]    boid_index;
  logic          boid_valid;
  logic [9:0]    boid_x;
  logic [8:0]    boid_y;
  logic          busy;
  logic [15:0]   frame_count;
  logic [7:0]    overrun_count;

  int n_vec = 0;
  int n_err = 0;
  int bx [NB];
  int by [NB];
  bit exp_img  [SIZE];
  bit prev_img [SIZE];
  int fixed_delay;
  bit resp_en;
  int n_hs;

  boid_frame_writer #(
    .NUM_BOIDS(NB), .MEM_W(MW), .MEM_H(MH), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .screen_end(screen_end),
    .read_address(read_address), .read_data(read_data),
    .boid_req(boid_req), .boid_index(boid_index), .boid_valid(boid_valid),
    .boid_x(boid_x), .boid_y(boid_y), .busy(busy),
    .frame_count(frame_count), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Expected back-bank image after drawing the current boid list.
  function automatic void build_image();
    int span;
    span = 1;
`ifdef BOID_FRAME_WIDE_EN
    span = 2;
`endif
    for (int a = 0; a < SIZE; a++) exp_img[a] = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (bx[i] < 2 * MW && by[i] < MH) begin
        for (int dy = 0; dy < span; dy++) begin
          for (int dx = 0; dx < span; dx++) begin
            if (bx[i] / 2 + dx < MW && by[i] + dy < MH)
              exp_img[bx[i] / 2 + dx + MW * (by[i] + dy)] = 1'b1;
          end
        end
      end
    end
  endfunction

  // Boid list per frame; boid 0 is always on screen.
  function automatic void gen_frame(input int f);
    for (int i = 0; i < NB; i++) begin
      bx[i] = int'($urandom_range(0, 2 * MW + 3));
      by[i] = int'($urandom_range(0, MH + 2));
      if (f == 1) begin
        if (i == 0) begin bx[i] = 2 * MW - 1; by[i] = MH - 1; end
        if (i == 1) begin bx[i] = 2 * MW;     by[i] = 10;     end
        if (i == 2) begin bx[i] = 5;          by[i] = MH;     end
      end else if (f == 2) begin
        bx[i] = 20; by[i] = 10;
      end else if (i == 0) begin
        bx[i] = int'($urandom_range(0, 2 * MW - 1));
        by[i] = int'($urandom_range(0, MH - 1));
      end
    end
  endfunction

  task automatic pulse_se();
    screen_end = 1'b1;
    repeat (2) @(negedge clk);
    screen_end = 1'b0;
    @(negedge clk);
  endtask

  // Upstream boid-state engine: answers each request after a chosen delay.
  initial begin : responder
    int cnt;
    int dly;
    logic [2:0] idx0;
    bit in_req;
    in_req = 1'b0; cnt = 0; dly = 0; idx0 = '0;
    boid_valid = 1'b0; boid_x = '0; boid_y = '0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        boid_valid = 1'b0;
        in_req = 1'b0;
      end else if (boid_req) begin
        if (!in_req) begin
          in_req = 1'b1;
          cnt = 0;
          idx0 = boid_index;
          dly = (fixed_delay < 0) ? int'($urandom_range(0, 3)) : fixed_delay;
        end
        chk("index_stable", 32'(boid_index), 32'(idx0));
        cnt++;
        if (cnt > dly) begin
          boid_valid = 1'b1;
          boid_x = 10'(bx[boid_index]);
          boid_y = 9'(by[boid_index]);
        end else begin
          boid_valid = 1'b0;
        end
      end else begin
        if (in_req) begin
          chk("req_cycles", cnt, dly + 1);
          chk("index_order", 32'(idx0), n_hs % NB);
          n_hs++;
          in_req = 1'b0;
        end
        boid_valid = 1'b0;
      end
    end
  end

  initial begin : main
    int cycles;
    int a1;
    reset = 1'b1; screen_end = 1'b0; read_address = '0;
    fixed_delay = -1; resp_en = 1'b1; n_hs = 0;
    gen_frame(1);
    for (int a = 0; a < SIZE; a++) prev_img[a] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_read_data", 32'(read_data), 0);
    chk("rst_boid_req", 32'(boid_req), 0);
    chk("rst_boid_index", 32'(boid_index), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_overrun", 32'(overrun_count), 0);
    reset = 1'b0;

    // Two boundaries during the initial CLEAR: counted, no swap.
    repeat (100) @(negedge clk);
    pulse_se();
    repeat (100) @(negedge clk);
    pulse_se();
    chk("overrun_mid_clear", 32'(overrun_count), 2);
    chk("no_swap_frame_count", 32'(frame_count), 0);
    chk("busy_in_clear", 32'(busy), 1);
    for (int k = 0; k < 5; k++) begin
      read_address = AW'($urandom_range(0, SIZE - 1));
      @(negedge clk);
      chk("read_before_first_swap", 32'(read_data), 0);
    end

    for (int f = 1; f <= 3; f++) begin
      cycles = 0;
      while (busy && cycles < 5000) begin
        @(negedge clk);
        cycles++;
      end
      chk("drawing_finished", 32'(busy), 0);
      chk("handshakes", n_hs, NB);
      n_hs = 0;
      build_image();
      a1 = bx[0] / 2 + MW * by[0];
      if (f < 3) begin
        gen_frame(f + 1);
        fixed_delay = (f + 1 == 2) ? 7 : 0;
      end
      read_address = AW'(a1);
      @(negedge clk);
      screen_end = 1'b1;
      @(negedge clk);
      chk("swap_edge1_old", 32'(read_data), 32'(prev_img[a1]));
      @(negedge clk);
      chk("swap_edge2_new", 32'(read_data), 1);
      screen_end = 1'b0;
      chk("frame_count", 32'(frame_count), f);
      chk("overrun_hold", 32'(overrun_count), 2);
      for (int a = 0; a < SIZE; a++) begin
        read_address = AW'(a);
        @(negedge clk);
        chk("image_pixel", 32'(read_data), 32'(exp_img[a]));
      end
      prev_img = exp_img;
    end

    // Asynchronous reset mid-operation.
    resp_en = 1'b0;
    read_address = AW'(a1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_frame_count", 32'(frame_count), 0);
    chk("arst_overrun", 32'(overrun_count), 0);
    chk("arst_busy", 32'(busy), 1);
    chk("arst_boid_req", 32'(boid_req), 0);
    chk("arst_boid_index", 32'(boid_index), 0);
    chk("arst_read_data", 32'(read_data), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("masked_after_reset", 32'(read_data), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
